weight_tare_filter: RTL and testbench
=====================================

# weight_tare_filter

Conditioning stage directly upstream of the price calculator. Takes raw gram samples from the load-cell front end and averages them over a 4-sample window. Detects when the reading is stable, captures a tare on operator request, and presents the net weight on `weightGrams` (14 bits) for price computation. It also flags overload so no price is shown for out-of-range loads.

## Interface
Parameters:
- `STABLE_CNT`, default 8: consecutive in-tolerance results needed to declare stable (1..15).
- `TOL`, default 2: maximum |avg − previous avg| in grams that still counts as in-tolerance.
- `MAX_GRAMS`, default 9999: largest averaged gross weight accepted before overload.

Ports:
- `clk`, in, 1: single system clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `sample_valid`, in, 1: one-cycle strobe; `sample_grams` is valid on this cycle.
- `sample_grams`, in, 14: raw gross weight in grams, unsigned.
- `tare_btn`, in, 1: tare button, already synchronised and debounced. Only its rising edge is used.
- `weightGrams`, out, 14: net weight in grams, registered.
- `weight_valid`, out, 1: one-cycle pulse marking a new `weightGrams`.
- `stable`, out, 1: the reading is settled.
- `tare_grams`, out, 14: currently stored tare.
- `tare_pending`, out, 1: a tare request is waiting for stability.
- `overload`, out, 1: the averaged gross weight exceeds `MAX_GRAMS`.

## Operation
- Window: 4×14-bit sample registers plus a 16-bit running sum.
  - On an accepted sample: sum ← sum + new − oldest, then shift the window.
  - avg = sum >> 2, truncated, 14 bits.
- FSM states:
  - FILL (reset state): counts accepted samples 0..3. On the 4th accepted sample, moves to MEASURE. No `weight_valid` pulses are produced in FILL.
  - MEASURE: every accepted sample produces one result update.
  - TARE_WAIT: identical to MEASURE, but with `tare_pending` = 1.
- Result update, performed in MEASURE and TARE_WAIT:
  - `overload` = (avg > MAX_GRAMS).
  - Net weight:
    - If overloaded: `weightGrams` = 0.
    - Else if avg ≤ tare: `weightGrams` = 0 (clip, never wrap).
    - Else: `weightGrams` = avg − tare.
  - Stability counter (4 bits):
    - Cleared on the first result after FILL.
    - Cleared when |avg − last_avg| > TOL.
    - Otherwise incremented, saturating at STABLE_CNT.
    - `stable` = (counter == STABLE_CNT).
    - last_avg ← avg.
- Tare:
  - A rising edge of `tare_btn` in MEASURE moves the FSM to TARE_WAIT.
  - A rising edge in TARE_WAIT or FILL is ignored.
  - In TARE_WAIT, on the result update where the new counter value equals STABLE_CNT and there is no overload: `tare_grams` ← avg, the FSM returns to MEASURE, and that same update uses the new tare, so `weightGrams` = 0.
  - An overload in TARE_WAIT cancels the request: the FSM returns to MEASURE and `tare_grams` is unchanged.
- A tare press and a result update in the same cycle: the update is performed first, then TARE_WAIT is entered. The tare is captured only on a later update.
- Reset mid-operation clears the window, sum, counters and tare, and returns the FSM to FILL.

## Timing
- A sample accepted at edge E updates the window and sum at E.
- `weightGrams`, `stable`, `overload`, `tare_grams` and the FSM update at E+1. `weight_valid` is high for the single cycle after E+1.
- Latency from sample strobe to result: 2 edges.
- `sample_valid` may be asserted every cycle. Back-to-back samples give back-to-back results with no stall. There is no ready signal: the block always accepts.
- The `tare_btn` edge detector is a 1-flop delay. The press is seen at the first edge where the current value is 1 and the previous value was 0.
- Reset values:
  - `weightGrams` = 0, `weight_valid` = 0, `stable` = 0.
  - `tare_grams` = 0, `tare_pending` = 0, `overload` = 0.
  - Sum = 0, FSM = FILL.

## Test plan
- Reset, then 4 samples of 1000: no `weight_valid` during the first 3. After the 4th, `weight_valid` pulses with `weightGrams` = 1000 and `stable` = 0.
- 12 further samples of 1000, 1001, 1000, … (within TOL): `stable` = 1 on the 8th result after the first. A subsequent sample of 1500 clears `stable` on the next result.
- Stable at 250, pulse `tare_btn`: `tare_pending` = 1 until the next stable update. Then `tare_grams` = 250 and `weightGrams` = 0. Feeding samples of 750 brings `weightGrams` to 500 once the window settles.
- With tare 250, feed samples of 100: `weightGrams` = 0, with no wrap to a large value.
- Feed samples of 12000: `overload` = 1 and `weightGrams` = 0. A pending tare is cancelled and `tare_grams` is unchanged.
- Assert `reset` while in TARE_WAIT with `sample_valid` toggling: all outputs read 0 immediately (asynchronous reset), and the next 3 samples produce no `weight_valid`.

Source files
------------

// File: rtl/weight_tare_filter.sv
// Load-cell conditioning: 4-sample moving average, stability detection,
// operator tare capture and overload flagging ahead of the price calculator.
module weight_tare_filter #(
    parameter int STABLE_CNT = 8,
    parameter int TOL        = 2,
    parameter int MAX_GRAMS  = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [13:0] sample_grams,
    input  logic        tare_btn,
    output logic [13:0] weightGrams,
    output logic        weight_valid,
    output logic        stable,
    output logic [13:0] tare_grams,
    output logic        tare_pending,
    output logic        overload
);

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        MEASURE   = 2'd1,
        TARE_WAIT = 2'd2
    } state_t;

    localparam logic [3:0]  STABLE_C = 4'(STABLE_CNT);
    localparam logic [13:0] TOL_C    = 14'(TOL);
    localparam logic [13:0] MAX_C    = 14'(MAX_GRAMS);

    state_t      state_r, state_next_s;
    logic [13:0] win_r [4];
    logic [15:0] sum_r;
    logic [1:0]  fill_cnt_r;
    logic        pend_r;
    logic        first_r;
    logic [3:0]  cnt_r;
    logic [13:0] last_avg_r;
    logic        tare_prev_r;

    logic [13:0] avg_s;
    logic [13:0] diff_s;
    logic        ovl_s;
    logic        press_s;
    logic [3:0]  cnt_next_s;
    logic        capture_s;
    logic [13:0] tare_use_s;
    logic [13:0] net_s;

    assign avg_s   = sum_r[15:2];
    assign ovl_s   = (avg_s > MAX_C);
    assign press_s = tare_btn & ~tare_prev_r;

    // Result datapath: stability counter, tare capture decision, clipped net weight.
    always_comb begin
        diff_s     = 14'd0;
        cnt_next_s = cnt_r;
        capture_s  = 1'b0;
        tare_use_s = tare_grams;
        net_s      = 14'd0;
        if (avg_s >= last_avg_r) begin
            diff_s = avg_s - last_avg_r;
        end else begin
            diff_s = last_avg_r - avg_s;
        end
        if (first_r || (diff_s > TOL_C)) begin
            cnt_next_s = 4'd0;
        end else if (cnt_r < STABLE_C) begin
            cnt_next_s = cnt_r + 4'd1;
        end else begin
            cnt_next_s = cnt_r;
        end
        // The capturing update already nets against the new tare, so it reads 0.
        if (pend_r && (state_r == TARE_WAIT) && !ovl_s && (cnt_next_s == STABLE_C)) begin
            capture_s  = 1'b1;
            tare_use_s = avg_s;
        end else begin
            capture_s  = 1'b0;
            tare_use_s = tare_grams;
        end
        if (ovl_s || (avg_s <= tare_use_s)) begin
            net_s = 14'd0;
        end else begin
            net_s = avg_s - tare_use_s;
        end
    end

    // Next-state logic for the fill / measure / tare-wait sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FILL: begin
                if (sample_valid && (fill_cnt_r == 2'd3)) begin
                    state_next_s = MEASURE;
                end else begin
                    state_next_s = FILL;
                end
            end
            MEASURE: begin
                if (press_s) begin
                    state_next_s = TARE_WAIT;
                end else begin
                    state_next_s = MEASURE;
                end
            end
            TARE_WAIT: begin
                if (pend_r && (ovl_s || capture_s)) begin
                    state_next_s = MEASURE;
                end else begin
                    state_next_s = TARE_WAIT;
                end
            end
            default: state_next_s = FILL;
        endcase
    end

    // Sample window, running sum and sequencer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= FILL;
            win_r[0]    <= 14'd0;
            win_r[1]    <= 14'd0;
            win_r[2]    <= 14'd0;
            win_r[3]    <= 14'd0;
            sum_r       <= 16'd0;
            fill_cnt_r  <= 2'd0;
            pend_r      <= 1'b0;
            first_r     <= 1'b0;
            tare_prev_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            tare_prev_r <= tare_btn;
            pend_r      <= sample_valid && ((state_r != FILL) || (fill_cnt_r == 2'd3));
            if (sample_valid) begin
                sum_r    <= sum_r + {2'b00, sample_grams} - {2'b00, win_r[3]};
                win_r[0] <= sample_grams;
                win_r[1] <= win_r[0];
                win_r[2] <= win_r[1];
                win_r[3] <= win_r[2];
            end
            if (sample_valid && (state_r == FILL)) begin
                fill_cnt_r <= fill_cnt_r + 2'd1;
            end
            if ((state_r == FILL) && (state_next_s == MEASURE)) begin
                first_r <= 1'b1;
            end else if (pend_r) begin
                first_r <= 1'b0;
            end
        end
    end

    // Registered result outputs, refreshed once per pending update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            weightGrams  <= 14'd0;
            weight_valid <= 1'b0;
            stable       <= 1'b0;
            tare_grams   <= 14'd0;
            tare_pending <= 1'b0;
            overload     <= 1'b0;
            cnt_r        <= 4'd0;
            last_avg_r   <= 14'd0;
        end else begin
            weight_valid <= pend_r;
            tare_pending <= (state_next_s == TARE_WAIT);
            if (pend_r) begin
                weightGrams <= net_s;
                overload    <= ovl_s;
                cnt_r       <= cnt_next_s;
                stable      <= (cnt_next_s == STABLE_C);
                last_avg_r  <= avg_s;
                tare_grams  <= tare_use_s;
            end
        end
    end

endmodule

// File: tb/tb_weight_tare_filter.sv
// Directed, table-driven bench for weight_tare_filter with hand-computed expectations.
module tb_weight_tare_filter;

    logic        clk;
    logic        reset;
    logic        sample_valid;
    logic [13:0] sample_grams;
    logic        tare_btn;
    logic [13:0] weightGrams;
    logic        weight_valid;
    logic        stable;
    logic [13:0] tare_grams;
    logic        tare_pending;
    logic        overload;

    int n_checks = 0;
    int n_errors = 0;

    weight_tare_filter dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_grams (sample_grams),
        .tare_btn     (tare_btn),
        .weightGrams  (weightGrams),
        .weight_valid (weight_valid),
        .stable       (stable),
        .tare_grams   (tare_grams),
        .tare_pending (tare_pending),
        .overload     (overload)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int grams;
        int reps;
        bit press;
        bit valid;
        int weight;
        bit stab;
        int tare;
        bit pend;
        bit ovl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int g, int r, bit p, bit v, int w, bit s, int t, bit pd, bit o);
        vec_t x;
        x.grams = g; x.reps = r; x.press = p; x.valid = v; x.weight = w;
        x.stab = s; x.tare = t; x.pend = pd; x.ovl = o;
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic press_tare();
        tare_btn = 1'b1;
        @(posedge clk); #1;
        tare_btn = 1'b0;
        @(posedge clk); #1;
        chk("tare_pending_after_press", int'(tare_pending), 1);
    endtask

    task automatic apply_row(input int idx, input vec_t v);
        if (v.press) press_tare();
        for (int r = 0; r < v.reps; r++) begin
            sample_valid = 1'b1;
            sample_grams = 14'(v.grams);
            @(posedge clk); #1;
            sample_valid = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("row%0d valid", idx), int'(weight_valid), int'(v.valid));
            chk($sformatf("row%0d weight", idx), int'(weightGrams), v.weight);
            chk($sformatf("row%0d stable", idx), int'(stable), int'(v.stab));
            chk($sformatf("row%0d tare", idx), int'(tare_grams), v.tare);
            chk($sformatf("row%0d pending", idx), int'(tare_pending), int'(v.pend));
            chk($sformatf("row%0d overload", idx), int'(overload), int'(v.ovl));
            @(posedge clk); #1;
            chk($sformatf("row%0d valid_drop", idx), int'(weight_valid), 0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " weight"},  int'(weightGrams), 0);
        chk({tag, " valid"},   int'(weight_valid), 0);
        chk({tag, " stable"},  int'(stable), 0);
        chk({tag, " tare"},    int'(tare_grams), 0);
        chk({tag, " pending"}, int'(tare_pending), 0);
        chk({tag, " overload"},int'(overload), 0);
    endtask

    initial begin
        reset        = 1'b0;
        sample_valid = 1'b0;
        sample_grams = 14'd0;
        tare_btn     = 1'b0;

        // grams, reps, press, valid, weight, stable, tare, pending, overload
        tbl.push_back(mk(1000, 3, 0, 0,    0, 0,   0, 0, 0));
        tbl.push_back(mk(1000, 1, 0, 1, 1000, 0,   0, 0, 0));
        tbl.push_back(mk(1001, 1, 0, 1, 1000, 0,   0, 0, 0));
        tbl.push_back(mk(1000, 1, 0, 1, 1000, 0,   0, 0, 0));
        tbl.push_back(mk(1001, 1, 0, 1, 1000, 0,   0, 0, 0));
        tbl.push_back(mk(1000, 1, 0, 1, 1000, 0,   0, 0, 0));
        tbl.push_back(mk(1001, 1, 0, 1, 1000, 0,   0, 0, 0));
        tbl.push_back(mk(1000, 1, 0, 1, 1000, 0,   0, 0, 0));
        tbl.push_back(mk(1001, 1, 0, 1, 1000, 0,   0, 0, 0));
        tbl.push_back(mk(1000, 1, 0, 1, 1000, 1,   0, 0, 0));
        tbl.push_back(mk(1001, 1, 0, 1, 1000, 1,   0, 0, 0));
        tbl.push_back(mk(1000, 1, 0, 1, 1000, 1,   0, 0, 0));
        tbl.push_back(mk(1001, 1, 0, 1, 1000, 1,   0, 0, 0));
        tbl.push_back(mk(1000, 1, 0, 1, 1000, 1,   0, 0, 0));
        tbl.push_back(mk(1500, 1, 0, 1, 1125, 0,   0, 0, 0));
        tbl.push_back(mk( 250, 1, 0, 1,  937, 0,   0, 0, 0));
        tbl.push_back(mk( 250, 1, 0, 1,  750, 0,   0, 0, 0));
        tbl.push_back(mk( 250, 1, 0, 1,  562, 0,   0, 0, 0));
        tbl.push_back(mk( 250, 1, 0, 1,  250, 0,   0, 0, 0));
        tbl.push_back(mk( 250, 7, 0, 1,  250, 0,   0, 0, 0));
        tbl.push_back(mk( 250, 1, 0, 1,  250, 1,   0, 0, 0));
        tbl.push_back(mk( 250, 1, 1, 1,    0, 1, 250, 0, 0));
        tbl.push_back(mk( 750, 1, 0, 1,  125, 0, 250, 0, 0));
        tbl.push_back(mk( 750, 1, 0, 1,  250, 0, 250, 0, 0));
        tbl.push_back(mk( 750, 1, 0, 1,  375, 0, 250, 0, 0));
        tbl.push_back(mk( 750, 1, 0, 1,  500, 0, 250, 0, 0));
        tbl.push_back(mk( 100, 1, 0, 1,  337, 0, 250, 0, 0));
        tbl.push_back(mk( 100, 1, 0, 1,  175, 0, 250, 0, 0));
        tbl.push_back(mk( 100, 1, 0, 1,   12, 0, 250, 0, 0));
        tbl.push_back(mk( 100, 2, 0, 1,    0, 0, 250, 0, 0));
        tbl.push_back(mk(12000,1, 1, 1, 2825, 0, 250, 1, 0));
        tbl.push_back(mk(12000,1, 0, 1, 5800, 0, 250, 1, 0));
        tbl.push_back(mk(12000,1, 0, 1, 8775, 0, 250, 1, 0));
        tbl.push_back(mk(12000,1, 0, 1,    0, 0, 250, 0, 1));
        tbl.push_back(mk( 100, 1, 0, 1, 8775, 0, 250, 0, 0));
        tbl.push_back(mk(9999, 1, 0, 1, 8274, 0, 250, 0, 0));
        tbl.push_back(mk(9999, 1, 0, 1, 7774, 0, 250, 0, 0));
        tbl.push_back(mk(9999, 1, 0, 1, 7274, 0, 250, 0, 0));
        tbl.push_back(mk(9999, 1, 0, 1, 9749, 0, 250, 0, 0));

        #2 reset = 1'b1;
        #3;
        chk_all_zero("reset");
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) apply_row(i, tbl[i]);

        // Reset while a tare request is pending and samples keep arriving.
        press_tare();
        sample_valid = 1'b1;
        sample_grams = 14'd500;
        #2 reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            sample_valid = ~sample_valid;
            chk("reset_hold valid", int'(weight_valid), 0);
        end
        @(negedge clk);
        reset        = 1'b0;
        sample_valid = 1'b0;
        @(posedge clk); #1;

        // Back-to-back samples after reset: refill, then one result per cycle.
        sample_valid = 1'b1;
        sample_grams = 14'd400;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b edge%0d valid", k), int'(weight_valid), (k >= 5) ? 1 : 0);
            if (k >= 5) chk($sformatf("b2b edge%0d weight", k), int'(weightGrams), 400);
        end
        sample_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b edge7 valid", int'(weight_valid), 1);
        chk("b2b edge7 tare", int'(tare_grams), 0);
        chk("b2b edge7 pending", int'(tare_pending), 0);
        @(posedge clk); #1;
        chk("b2b edge8 valid", int'(weight_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
